addsub_rr_scheduler: RTL and testbench
======================================

Name: addsub_rr_scheduler

Overview:
- Shares one WIDTH-bit ripple adder-subtractor datapath between two requesters (e.g. the ALU front-end and the address/compare unit).
- Arbitrates round-robin and latches the winner's operands and opcode.
- Sequences the operation through a 3-state FSM.
- Returns a registered sum/difference with carry/borrow and signed-overflow flags, tagged with the requester ID.

Parameters:
WIDTH, 16, operand/result width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 wants an operation
a0  input  WIDTH  requester 0 augend/minuend
b0  input  WIDTH  requester 0 addend/subtrahend
op0  input  1  requester 0 operation: 0 = add, 1 = subtract
ack0  output  1  one-cycle pulse: requester 0 operands accepted
req1  input  1  requester 1 wants an operation
a1  input  WIDTH  requester 1 augend/minuend
b1  input  WIDTH  requester 1 addend/subtrahend
op1  input  1  requester 1 operation: 0 = add, 1 = subtract
ack1  output  1  one-cycle pulse: requester 1 operands accepted
busy  output  1  high while FSM not in IDLE
done  output  1  one-cycle pulse: result/carry/overflow/done_id valid
done_id  output  1  requester that owns the current result
result  output  WIDTH  sum or difference
carry  output  1  add: carry-out; subtract: borrow (NOT carry-out)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - state = IDLE, rr_last = 1 (requester 0 wins first tie)
  - ack0 = ack1 = busy = done = done_id = 0
  - result = 0, carry = 0, overflow = 0
  - internal operand latches = 0
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if neither req is high, stay. If exactly one req is high, grant it. If both are high, grant the requester != rr_last. On grant:
    - latch a/b/op and id
    - pulse ackN for that cycle (combinational from IDLE and grant, registered-state based)
    - set rr_last = granted id
    - next state = EXEC
  - EXEC: compute from the latched operands.
    - B' = b XOR {WIDTH{op}}, cin = op
    - {cout, sum} = a + B' + cin
    - c_msb_in = carry into the MSB
    - Register result = sum, carry = cout XOR op, overflow = cout XOR c_msb_in, done_id = id
    - next state = RESP
  - RESP: done = 1 for exactly this cycle. Next state = IDLE.
- Latency: acceptance edge N → done high in cycle N+2. Throughput: 1 op per 3 cycles; no acceptance in EXEC/RESP.
- busy = 1 in EXEC and RESP, 0 in IDLE.
- result/carry/overflow/done_id hold their values after done falls, until the next EXEC update.
- Handshake rules:
  - Requester holds reqN and operands stable until ackN.
  - Operands are sampled only on the ack cycle; later changes are ignored.
  - A req held high after ack is treated as a new request at the next IDLE.
  - A req dropped before ack causes no grant; no error is flagged.
- Fairness: with both reqs held continuously, grants strictly alternate, so neither requester waits more than one operation.
- Reset mid-operation (EXEC or RESP):
  - in-flight op is discarded; done is never asserted for it
  - all outputs take reset values immediately, without waiting for a clock edge
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Test Plan:
- Req0 add a0=0x7FFF, b0=0x0001 → ack0 at N, done at N+2, done_id=0, result=0x8000, carry=0, overflow=1.
- Req1 sub a1=0x0003, b1=0x0005 → done_id=1, result=0xFFFE, carry=1 (borrow), overflow=0. Then sub 0x8000−0x0001 → 0x7FFF, carry=0, overflow=1.
- Add 0xFFFF+0x0001 → result=0x0000, carry=1, overflow=0. Sub 0x1234−0x1234 → 0x0000, carry=0, overflow=0.
- Both reqs held high from reset, distinct operands → grants 0,1,0,1 with acks 3 cycles apart. done_id matches each grant order. busy is low only on the acceptance cycles.
- Assert rst during EXEC of an add 0x0010+0x0020 → outputs zero asynchronously, no done pulse. After release with req1 high: ack1 first if req0 low; if both high, ack0 first (rr_last reset to 1).
- Change a0/b0 the cycle after ack0 → result reflects only the values sampled on the ack cycle. Pulse req0 one cycle while busy → no ack, no extra done.

Source files
------------

// File: rtl/addsub_rr_scheduler.sv
// Two requesters share one adder-subtractor via a round-robin arbiter; ack in IDLE, done two cycles later.
// No acceptance while busy (EXEC/RESP): requesters hold req and operands until their ack pulse.
module addsub_rr_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             op0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             op1,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             done_id_q, done_id_d;

  logic             gnt0, gnt1;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] low_sum;
  logic [1:0]       top_sum;

  // Gated by rst so acks read zero while reset is held, not just after the next edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      gnt0 = req0 && (!req1 || rr_last_q);
      gnt1 = req1 && (!req0 || !rr_last_q);
    end
  end

  // The MSB is added separately so the carry into it is visible for the overflow flag.
  always_comb begin
    b_x     = b_q ^ {WIDTH{op_q}};
    low_sum = {1'b0, a_q[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, op_q};
    top_sum = {1'b0, a_q[WIDTH-1]} + {1'b0, b_x[WIDTH-1]} + {1'b0, low_sum[WIDTH-1]};
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    done_id_d  = done_id_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          a_d       = gnt1 ? a1 : a0;
          b_d       = gnt1 ? b1 : b0;
          op_d      = gnt1 ? op1 : op0;
          id_d      = gnt1;
          rr_last_d = gnt1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d   = {top_sum[0], low_sum[WIDTH-2:0]};
        carry_d    = top_sum[1] ^ op_q;
        overflow_d = top_sum[1] ^ low_sum[WIDTH-1];
        done_id_d  = id_q;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_id_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      id_q       <= id_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      done_id_q  <= done_id_d;
    end
  end

  assign ack0     = gnt0;
  assign ack1     = gnt1;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == RESP);
  assign done_id  = done_id_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Bench for addsub_rr_scheduler: directed corner ops, fairness, async reset, then random traffic
// checked every cycle against an arithmetic/transaction-level reference model.
module tb_addsub_rr_scheduler;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, op0, req1, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, busy, done, done_id, carry, overflow;
  logic [W-1:0] result;

  addsub_rr_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1), .ack1(ack1),
    .busy(busy), .done(done), .done_id(done_id),
    .result(result), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles remaining in the current operation, arbitration memory, visible outputs.
  int           m_phase;
  bit           m_last;
  bit           m_g0, m_g1;
  logic [W-1:0] p_r, vis_r;
  bit           p_c, p_v, p_id, vis_c, vis_v, vis_id;

  int cyc = 0;
  int ack_cyc, done_cyc, done_count;
  bit last_ack0, last_ack1;
  int gq[$];
  int gcyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input bit op,
                                   output logic [W-1:0] r, output bit c, output bit v);
    int ua, ub, sa, sb, full, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) begin
      full = ua + ub;
      c    = (full >= (1 << W));
      sr   = sa + sb;
    end else begin
      full = ua - ub;
      c    = (ua < ub);
      sr   = sa - sb;
    end
    r = full[W-1:0];
    v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    vis_r   = '0;
    vis_c   = 1'b0;
    vis_v   = 1'b0;
    vis_id  = 1'b0;
  endfunction

  task automatic cycle();
    bit g0, g1, win;
    @(negedge clk);
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (m_phase == 0 && (req0 || req1)) begin
      win = (req0 && req1) ? !m_last : req1;
      g0  = !win;
      g1  = win;
    end
    chk("ctl{ack0,ack1,busy,done}", 32'({ack0, ack1, busy, done}),
        32'({g0, g1, (m_phase != 0), (m_phase == 1)}));
    chk("out{id,carry,ovf,result}", 32'({done_id, carry, overflow, result}),
        32'({vis_id, vis_c, vis_v, vis_r}));
    last_ack0 = ack0;
    last_ack1 = ack1;
    if (ack0 || ack1) ack_cyc = cyc;
    if (ack0) begin gq.push_back(0); gcyc.push_back(cyc); end
    if (ack1) begin gq.push_back(1); gcyc.push_back(cyc); end
    if (done) begin done_cyc = cyc; done_count++; end
    if (m_phase == 2) begin
      vis_r = p_r; vis_c = p_c; vis_v = p_v; vis_id = p_id;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 0;
    end else if (g0 || g1) begin
      p_id = g1;
      if (g1) ref_calc(a1, b1, op1, p_r, p_c, p_v);
      else    ref_calc(a0, b0, op0, p_r, p_c, p_v);
      m_last  = g1;
      m_phase = 2;
    end
    m_g0 = g0;
    m_g1 = g1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit op);
    if (id) begin req1 = r; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = r; a0 = a; b0 = b; op0 = op; end
  endtask

  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit op,
                       input logic [W-1:0] er, input bit ec, input bit ev, input bit scramble);
    int guard;
    ack_cyc  = -1;
    done_cyc = -1;
    set_req(id, 1'b1, a, b, op);
    guard = 0;
    while (ack_cyc < 0 && guard < 8) begin cycle(); guard++; end
    if (scramble) set_req(id, 1'b0, 16'hAAAA, 16'h5555, !op);
    else          set_req(id, 1'b0, a, b, op);
    guard = 0;
    while (done_cyc < 0 && guard < 8) begin cycle(); guard++; end
    chk("latency ack->done", 32'(done_cyc - ack_cyc), 32'd2);
    chk("result", 32'(result), 32'(er));
    chk("carry", 32'(carry), 32'(ec));
    chk("overflow", 32'(overflow), 32'(ev));
    chk("done_id", 32'(done_id), 32'(id));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] v;
    case ($urandom_range(5))
      0:       v = 16'h7FFF;
      1:       v = 16'h8000;
      2:       v = 16'hFFFF;
      3:       v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'({ack0, ack1, busy, done, done_id, carry, overflow, result}), 32'd0);
    rst = 1'b0;
    model_reset();

    do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    do_op(1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

    // A one-cycle req0 pulse while busy must neither be acked nor produce a second done.
    ack_cyc = -1;
    set_req(1'b1, 1'b1, 16'h0100, 16'h0200, 1'b0);
    guard = 0;
    while (ack_cyc < 0 && guard < 8) begin cycle(); guard++; end
    done_count = 0;
    set_req(1'b1, 1'b0, 16'h0100, 16'h0200, 1'b0);
    set_req(1'b0, 1'b1, 16'h0011, 16'h0022, 1'b0);
    cycle();
    chk("no ack0 while busy", 32'(last_ack0), 32'd0);
    set_req(1'b0, 1'b0, 16'h0011, 16'h0022, 1'b0);
    repeat (6) cycle();
    chk("single done", 32'(done_count), 32'd1);
    chk("busy-pulse result", 32'(result), 32'h0300);

    // Reset during EXEC discards the add and clears outputs without a clock edge.
    ack_cyc = -1;
    set_req(1'b0, 1'b1, 16'h0010, 16'h0020, 1'b0);
    guard = 0;
    while (ack_cyc < 0 && guard < 8) begin cycle(); guard++; end
    set_req(1'b0, 1'b0, 16'h0010, 16'h0020, 1'b0);
    rst = 1'b1;
    #1;
    chk("async reset outputs", 32'({ack0, ack1, busy, done, done_id, carry, overflow, result}), 32'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("no done in reset", 32'({done, busy}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(1'b1, 1'b1, 16'h0040, 16'h0004, 1'b1);
    cycle();
    chk("post-reset lone req1", 32'({last_ack0, last_ack1}), 32'd1);
    set_req(1'b1, 1'b0, 16'h0040, 16'h0004, 1'b1);
    repeat (3) cycle();
    chk("post-reset result", 32'(result), 32'h003C);

    // Both requesters held from reset: grants alternate starting with requester 0.
    rst = 1'b1;
    set_req(1'b0, 1'b1, 16'h1000, 16'h0001, 1'b0);
    set_req(1'b1, 1'b1, 16'h2000, 16'h0002, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    gq.delete();
    gcyc.delete();
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (m_g0) set_req(1'b0, 1'b1, 16'h1000 + 16'(i), 16'h0001, 1'b0);
      if (m_g1) set_req(1'b1, 1'b1, 16'h2000 + 16'(i), 16'h0002, 1'b1);
    end
    chk("fair grant count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk("fair grant order", 32'(gq[i]), 32'(i % 2));
      if (i > 0) chk("fair grant spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end

    // Random traffic; requesters sometimes drop before ack and often re-request after it.
    for (int t = 0; t < 400; t++) begin
      cycle();
      if (m_g0) begin
        if ($urandom_range(1) == 0) req0 = 1'b0;
        else set_req(1'b0, 1'b1, rnd_opnd(), rnd_opnd(), 1'($urandom_range(1)));
      end else if (!req0 && $urandom_range(2) == 0) begin
        set_req(1'b0, 1'b1, rnd_opnd(), rnd_opnd(), 1'($urandom_range(1)));
      end else if (req0 && $urandom_range(9) == 0) begin
        req0 = 1'b0;
      end
      if (m_g1) begin
        if ($urandom_range(1) == 0) req1 = 1'b0;
        else set_req(1'b1, 1'b1, rnd_opnd(), rnd_opnd(), 1'($urandom_range(1)));
      end else if (!req1 && $urandom_range(2) == 0) begin
        set_req(1'b1, 1'b1, rnd_opnd(), rnd_opnd(), 1'($urandom_range(1)));
      end else if (req1 && $urandom_range(9) == 0) begin
        req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
